// File: rtl/reg_wb_arbiter.sv
// Write-port arbiter for the register file: shares one registered write port between
// the pipeline write-back (A, fixed priority) and the long-latency unit (B, anti-starvation).
module reg_wb_arbiter #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] REG_address_wb,
  output logic [DATA_W-1:0] data_wb,
  output logic              b_forced
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StAPrio, StBPrio} state_e;

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              a_xfer, b_xfer;
  logic              regwrite_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAPrio;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    // Any cycle B is valid but not transferred counts as a refusal.
    if (!b_valid || b_xfer) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != Limit) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    unique case (state_q)
      StAPrio: if (wait_cnt_d == Limit) state_d = StBPrio;
      StBPrio: if (b_xfer || !b_valid) state_d = StAPrio;
      default: state_d = StAPrio;
    endcase
  end

  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    b_forced = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StAPrio: begin
          a_ready = 1'b1;
          b_ready = !a_valid;
        end
        StBPrio: begin
          b_ready  = 1'b1;
          b_forced = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Writes to r0 are accepted upstream but never enabled toward the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else if (a_xfer) begin
      regwrite_q <= (a_addr != '0);
      wb_addr_q  <= a_addr;
      wb_data_q  <= a_data;
    end else if (b_xfer) begin
      regwrite_q <= (b_addr != '0);
      wb_addr_q  <= b_addr;
      wb_data_q  <= b_data;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign regwrite       = regwrite_q;
  assign REG_address_wb = wb_addr_q;
  assign data_wb        = wb_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, a protocol-violation sequence,
// then random traffic checked against a refusal-counting reference model.
module tb_reg_wb_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, regwrite, b_forced;
  logic [4:0]  REG_address_wb;
  logic [31:0] data_wb;

  int total = 0;
  int bad   = 0;

  logic [31:0] regs [32] = '{default: 32'h0};

  reg_wb_arbiter #(
    .ADDR_W      (5),
    .DATA_W      (32),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .regwrite      (regwrite),
    .REG_address_wb(REG_address_wb),
    .data_wb       (data_wb),
    .b_forced      (b_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in fed by the write port.
  always @(posedge clk) begin
    if (regwrite) regs[REG_address_wb] <= data_wb;
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        bf;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cr;
    logic [31:0] ce;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                              input logic [31:0] bd, input logic ar, input logic br,
                              input logic bf, input logic rw, input logic [4:0] wa,
                              input logic [31:0] wd, input int cr = -1,
                              input logic [31:0] ce = 32'h0);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ar = ar; v.br = br; v.bf = bf; v.rw = rw; v.wa = wa; v.wd = wd; v.cr = cr; v.ce = ce;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset   = v.rst;
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    #1;
    chk("a_ready", {31'b0, a_ready}, {31'b0, v.ar});
    chk("b_ready", {31'b0, b_ready}, {31'b0, v.br});
    chk("b_forced", {31'b0, b_forced}, {31'b0, v.bf});
    @(posedge clk);
    #1;
    chk("regwrite", {31'b0, regwrite}, {31'b0, v.rw});
    chk("REG_address_wb", {27'b0, REG_address_wb}, {27'b0, v.wa});
    chk("data_wb", data_wb, v.wd);
    if (v.cr >= 0) chk($sformatf("REG r%0d", v.cr), regs[v.cr], v.ce);
  endtask

  // Reference model state
  int          m_refused;
  bit          m_forced;
  bit          m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          a_pend, b_pend;
  logic [4:0]  pa, pb;
  logic [31:0] pad, pbd;

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

    // rst av aa ad bv ba bd | ar br bf | rw wa wd | reg check
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 1, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 2, 32'hCAFEBABE, 1, 3, 32'h12345678, 1, 0, 0, 1, 2, 32'hCAFEBABE));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 32'h12345678, 1, 1, 0, 1, 3, 32'h12345678,
                     2, 32'hCAFEBABE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 32'h12345678, 3, 32'h12345678));
    for (int k = 1; k <= 4; k++) begin
      tbl.push_back(mk(0, 1, 4, 32'h44440000 + 32'(k), 1, 5, 32'h87654321, 1, 0, 0,
                       1, 4, 32'h44440000 + 32'(k)));
    end
    tbl.push_back(mk(0, 1, 4, 32'h44440005, 1, 5, 32'h87654321, 0, 1, 1, 1, 5, 32'h87654321));
    tbl.push_back(mk(0, 1, 4, 32'h44440005, 0, 0, 0, 1, 0, 0, 1, 4, 32'h44440005,
                     5, 32'h87654321));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 32'h44440005));
    tbl.push_back(mk(0, 1, 4, 32'h44440006, 1, 5, 32'h55555555, 1, 0, 0, 1, 4, 32'h44440006));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 32'h55555555, 1, 1, 0, 1, 5, 32'h55555555));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(0, 1, 6, 32'hABCDEF01, 0, 0, 0, 1, 0, 0, 1, 6, 32'hABCDEF01));
    tbl.push_back(mk(1, 1, 6, 32'hABCDEF01, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 6, 32'hABCDEF01, 0, 0, 0, 1, 0, 0, 1, 6, 32'hABCDEF01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6, 32'hABCDEF01, 6, 32'hABCDEF01));
    tbl.push_back(mk(0, 1, 7, 32'h00110011, 0, 0, 0, 1, 0, 0, 1, 7, 32'h00110011));
    tbl.push_back(mk(0, 0, 0, 0, 1, 7, 32'h11001100, 1, 1, 0, 1, 7, 32'h11001100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 32'h11001100, 7, 32'h11001100));

    foreach (tbl[i]) apply(tbl[i]);

    // B starved into forced priority, then drops valid: no transfer, A regains the port.
    for (int k = 1; k <= 4; k++) begin
      apply(mk(0, 1, 8, 32'h80 + 32'(k), 1, 9, 32'h99, 1, 0, 0, 1, 8, 32'h80 + 32'(k)));
    end
    apply(mk(0, 1, 8, 32'h85, 0, 0, 0, 0, 1, 1, 0, 8, 32'h84));
    apply(mk(0, 1, 8, 32'h85, 0, 0, 0, 1, 0, 0, 1, 8, 32'h85, 7, 32'h11001100));

    // Random traffic against the reference model
    m_refused = 0; m_forced = 0; m_rw = 0; m_wa = '0; m_wd = '0;
    a_pend = 0; b_pend = 0; pa = '0; pb = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 400; i++) begin
      bit rst, m_ar, m_br, ax, bx;
      @(negedge clk);
      rst = (i < 2) || ($urandom_range(0, 59) == 0);
      if (!a_pend && $urandom_range(0, 2) != 0) begin
        a_pend = 1; pa = 5'($urandom_range(0, 31)); pad = $urandom;
      end
      if (!b_pend && $urandom_range(0, 1) != 0) begin
        b_pend = 1; pb = 5'($urandom_range(0, 31)); pbd = $urandom;
      end
      reset   = rst;
      a_valid = a_pend; a_addr = pa; a_data = pad;
      b_valid = b_pend; b_addr = pb; b_data = pbd;
      m_ar = !rst && !m_forced;
      m_br = !rst && (m_forced || !a_pend);
      #1;
      chk("rand a_ready", {31'b0, a_ready}, {31'b0, m_ar});
      chk("rand b_ready", {31'b0, b_ready}, {31'b0, m_br});
      chk("rand b_forced", {31'b0, b_forced}, {31'b0, m_forced && !rst});
      ax = a_pend && m_ar;
      bx = b_pend && m_br;
      if (rst) begin
        m_rw = 0; m_wa = '0; m_wd = '0; m_refused = 0; m_forced = 0;
      end else begin
        if (ax) begin
          m_rw = (pa != 0); m_wa = pa; m_wd = pad;
        end else if (bx) begin
          m_rw = (pb != 0); m_wa = pb; m_wd = pbd;
        end else begin
          m_rw = 0;
        end
        if (m_forced) begin
          m_forced = 0; m_refused = 0;
        end else if (b_pend && !bx) begin
          m_refused = (m_refused + 1 > int'(Limit)) ? int'(Limit) : m_refused + 1;
          if (m_refused == int'(Limit)) m_forced = 1;
        end else begin
          m_refused = 0;
        end
      end
      if (ax) a_pend = 0;
      if (bx) b_pend = 0;
      @(posedge clk);
      #1;
      chk("rand regwrite", {31'b0, regwrite}, {31'b0, m_rw});
      chk("rand REG_address_wb", {27'b0, REG_address_wb}, {27'b0, m_wa});
      chk("rand data_wb", data_wb, m_wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
